// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD image controller: command codes and FSM states.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] CMD_WRITE    = 4'd0;
  localparam logic [3:0] CMD_UP       = 4'd1;
  localparam logic [3:0] CMD_DOWN     = 4'd2;
  localparam logic [3:0] CMD_LEFT     = 4'd3;
  localparam logic [3:0] CMD_RIGHT    = 4'd4;
  localparam logic [3:0] CMD_MAX      = 4'd5;
  localparam logic [3:0] CMD_MIN      = 4'd6;
  localparam logic [3:0] CMD_AVG      = 4'd7;
  localparam logic [3:0] CMD_CCW      = 4'd8;
  localparam logic [3:0] CMD_CW       = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y = 4'd11;
  localparam logic [3:0] CMD_HOME     = 4'd12;
  localparam logic [3:0] CMD_SNAPSHOT = 4'd13;
  localparam logic [3:0] CMD_RSV14    = 4'd14;
  localparam logic [3:0] CMD_RSV15    = 4'd15;

  // Commands that stream the whole buffer out instead of taking one EXEC cycle.
  function automatic logic is_dump_cmd(input logic [3:0] c);
    return (c == CMD_WRITE) || (c == CMD_SNAPSHOT);
  endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational max / min / floor-average of the four 2x2 window pixels.
module lcd_win_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] p0,
  input  logic [DW-1:0] p1,
  input  logic [DW-1:0] p2,
  input  logic [DW-1:0] p3,
  output logic [DW-1:0] max_px,
  output logic [DW-1:0] min_px,
  output logic [DW-1:0] avg_px
);

  logic [DW-1:0] max_a_s, max_b_s, min_a_s, min_b_s;
  logic [DW+1:0] sum_s;

  // Pairwise reduction trees and a two-bit-wider sum so the average cannot overflow
  always_comb begin
    max_a_s = (p0 > p1) ? p0 : p1;
    max_b_s = (p2 > p3) ? p2 : p3;
    min_a_s = (p0 < p1) ? p0 : p1;
    min_b_s = (p2 < p3) ? p2 : p3;
    max_px  = (max_a_s > max_b_s) ? max_a_s : max_b_s;
    min_px  = (min_a_s < min_b_s) ? min_a_s : min_b_s;
    sum_s   = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    avg_px  = sum_s[DW+1:2];
  end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// LCD image controller: loads an image from IROM, applies 2x2 window commands,
// and streams the buffer to IRAM on Write/Snapshot.
module lcd_ctrl_gen
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  localparam int N    = IMG_W * IMG_H,
  localparam int AW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  output logic          IRAM_valid,
  output logic [DW-1:0] IRAM_D,
  output logic [AW-1:0] IRAM_A,
  output logic          busy,
  output logic          done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_HOME = RW'(IMG_H / 2 - 1);
  localparam logic [CW-1:0] COL_HOME = CW'(IMG_W / 2 - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 2);
  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 2);
  localparam logic [AW-1:0] LAST_PX  = AW'(N - 1);

  state_t        state_r, state_next_s;
  logic [AW-1:0] cnt_r, cnt_next_s;
  logic [RW-1:0] row_r, row_next_s;
  logic [CW-1:0] col_r, col_next_s;
  logic [3:0]    cmd_r, cmd_next_s;
  logic [DW-1:0] buf_r [N];

  // Power-of-two geometry makes a pixel address simply {row, col}.
  logic [AW-1:0] idx0_s, idx1_s, idx2_s, idx3_s;
  logic [DW-1:0] p0_s, p1_s, p2_s, p3_s, n0_s, n1_s, n2_s, n3_s;
  logic [DW-1:0] max_s, min_s, avg_s;
  logic          win_we_s, load_we_s;

  assign idx0_s = {row_r, col_r};
  assign idx1_s = {row_r, col_r + CW'(1'b1)};
  assign idx2_s = {row_r + RW'(1'b1), col_r};
  assign idx3_s = {row_r + RW'(1'b1), col_r + CW'(1'b1)};
  assign p0_s   = buf_r[idx0_s];
  assign p1_s   = buf_r[idx1_s];
  assign p2_s   = buf_r[idx2_s];
  assign p3_s   = buf_r[idx3_s];

  lcd_win_alu #(.DW(DW)) u_alu (
    .p0(p0_s), .p1(p1_s), .p2(p2_s), .p3(p3_s),
    .max_px(max_s), .min_px(min_s), .avg_px(avg_s)
  );

  // State, counter, window origin and latched command registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_LOAD;
      cnt_r   <= {AW{1'b0}};
      row_r   <= ROW_HOME;
      col_r   <= COL_HOME;
      cmd_r   <= CMD_WRITE;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      row_r   <= row_next_s;
      col_r   <= col_next_s;
      cmd_r   <= cmd_next_s;
    end
  end

  // Next-state and pixel counter; the counter is only non-zero in LOAD and WRITE
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = {AW{1'b0}};
    cmd_next_s   = cmd_r;
    case (state_r)
      ST_LOAD: begin
        if (cnt_r == LAST_PX) state_next_s = ST_IDLE;
        else                  cnt_next_s   = cnt_r + AW'(1'b1);
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_next_s   = cmd;
          state_next_s = is_dump_cmd(cmd) ? ST_WRITE : ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: state_next_s = ST_IDLE;
      ST_WRITE: begin
        if (cnt_r == LAST_PX) state_next_s = (cmd_r == CMD_WRITE) ? ST_DONE : ST_IDLE;
        else                  cnt_next_s   = cnt_r + AW'(1'b1);
      end
      ST_DONE: state_next_s = ST_DONE;
      default: state_next_s = ST_LOAD;
    endcase
  end

  // Window command decode: origin moves and new values for the four window pixels
  always_comb begin
    row_next_s = row_r;
    col_next_s = col_r;
    n0_s = p0_s; n1_s = p1_s; n2_s = p2_s; n3_s = p3_s;
    win_we_s = 1'b0;
    if (state_r == ST_EXEC) begin
      case (cmd_r)
        CMD_UP:    if (row_r != {RW{1'b0}}) row_next_s = row_r - RW'(1'b1); else row_next_s = row_r;
        CMD_DOWN:  if (row_r < ROW_MAX)     row_next_s = row_r + RW'(1'b1); else row_next_s = row_r;
        CMD_LEFT:  if (col_r != {CW{1'b0}}) col_next_s = col_r - CW'(1'b1); else col_next_s = col_r;
        CMD_RIGHT: if (col_r < COL_MAX)     col_next_s = col_r + CW'(1'b1); else col_next_s = col_r;
        CMD_MAX:      begin n0_s = max_s; n1_s = max_s; n2_s = max_s; n3_s = max_s; win_we_s = 1'b1; end
        CMD_MIN:      begin n0_s = min_s; n1_s = min_s; n2_s = min_s; n3_s = min_s; win_we_s = 1'b1; end
        CMD_AVG:      begin n0_s = avg_s; n1_s = avg_s; n2_s = avg_s; n3_s = avg_s; win_we_s = 1'b1; end
        CMD_CCW:      begin n0_s = p1_s; n1_s = p3_s; n2_s = p0_s; n3_s = p2_s; win_we_s = 1'b1; end
        CMD_CW:       begin n0_s = p2_s; n1_s = p0_s; n2_s = p3_s; n3_s = p1_s; win_we_s = 1'b1; end
        CMD_MIRROR_X: begin n0_s = p2_s; n1_s = p3_s; n2_s = p0_s; n3_s = p1_s; win_we_s = 1'b1; end
        CMD_MIRROR_Y: begin n0_s = p1_s; n1_s = p0_s; n2_s = p3_s; n3_s = p2_s; win_we_s = 1'b1; end
        CMD_HOME:     begin row_next_s = ROW_HOME; col_next_s = COL_HOME; end
        default:      win_we_s = 1'b0;
      endcase
    end else begin
      win_we_s = 1'b0;
    end
  end

  // The buffer is never reset; loading is held off while reset is asserted
  always_comb begin
    load_we_s = reset && (state_r == ST_LOAD);
  end

  // Pixel buffer writes: ROM fill during LOAD, window update at the end of EXEC
  always_ff @(posedge clk) begin
    if (load_we_s) begin
      buf_r[cnt_r] <= IROM_Q;
    end else if (win_we_s) begin
      buf_r[idx0_s] <= n0_s;
      buf_r[idx1_s] <= n1_s;
      buf_r[idx2_s] <= n2_s;
      buf_r[idx3_s] <= n3_s;
    end
  end

  // Moore output decode from the state register
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    IROM_rd    = 1'b0;
    IRAM_valid = 1'b0;
    IRAM_D     = {DW{1'b0}};
    case (state_r)
      ST_LOAD:  begin busy = 1'b1; IROM_rd = 1'b1; end
      ST_IDLE:  busy = 1'b0;
      ST_EXEC:  busy = 1'b1;
      ST_WRITE: begin busy = 1'b1; IRAM_valid = 1'b1; IRAM_D = buf_r[cnt_r]; end
      ST_DONE:  done = 1'b1;
      default:  busy = 1'b1;
    endcase
  end

  assign IROM_A = cnt_r;
  assign IRAM_A = cnt_r;

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Scoreboard bench for lcd_ctrl_gen: an 8x8 and a 16x4 instance checked against an array model.
module tb_lcd_ctrl_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cmd = 4'd0;
  logic       cmd_valid = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] rom [64];

  logic [7:0] q8, q16, wd8, wd16;
  logic [5:0] ra8, ra16, wa8, wa16;
  logic       rd8, rd16, wv8, wv16, busy8, busy16, done8, done16, cv8, cv16;

  always #5 clk = ~clk;

  assign q8   = rom[ra8];
  assign q16  = rom[ra16];
  assign cv8  = cmd_valid & ~sel;
  assign cv16 = cmd_valid & sel;

  lcd_ctrl_gen #(.IMG_W(8), .IMG_H(8), .DW(8)) dut8 (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cv8), .IROM_Q(q8),
    .IROM_rd(rd8), .IROM_A(ra8), .IRAM_valid(wv8), .IRAM_D(wd8), .IRAM_A(wa8),
    .busy(busy8), .done(done8)
  );

  lcd_ctrl_gen #(.IMG_W(16), .IMG_H(4), .DW(8)) dut16 (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cv16), .IROM_Q(q16),
    .IROM_rd(rd16), .IROM_A(ra16), .IRAM_valid(wv16), .IRAM_D(wd16), .IRAM_A(wa16),
    .busy(busy16), .done(done16)
  );

  // Outputs of whichever instance is under test
  logic       rd_m, wv_m, busy_m, done_m;
  logic [5:0] ra_m, wa_m;
  logic [7:0] wd_m;
  assign rd_m   = sel ? rd16   : rd8;
  assign wv_m   = sel ? wv16   : wv8;
  assign busy_m = sel ? busy16 : busy8;
  assign done_m = sel ? done16 : done8;
  assign ra_m   = sel ? ra16   : ra8;
  assign wa_m   = sel ? wa16   : wa8;
  assign wd_m   = sel ? wd16   : wd8;

  int vectors = 0;
  int errors  = 0;

  typedef struct { int a; int d; } wr_t;
  wr_t exp_q[$];

  int mbuf [64];
  int mrow, mcol, mw, mh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of one window command on the image array
  task automatic model_apply(input int c);
    int i0, i1, i2, i3, p0, p1, p2, p3, n0, n1, n2, n3, v;
    i0 = mrow * mw + mcol; i1 = i0 + 1; i2 = i0 + mw; i3 = i2 + 1;
    p0 = mbuf[i0]; p1 = mbuf[i1]; p2 = mbuf[i2]; p3 = mbuf[i3];
    n0 = p0; n1 = p1; n2 = p2; n3 = p3;
    case (c)
      1:  if (mrow > 0) mrow--;
      2:  if (mrow < mh - 2) mrow++;
      3:  if (mcol > 0) mcol--;
      4:  if (mcol < mw - 2) mcol++;
      5:  begin v = p0; if (p1 > v) v = p1; if (p2 > v) v = p2; if (p3 > v) v = p3;
                n0 = v; n1 = v; n2 = v; n3 = v; end
      6:  begin v = p0; if (p1 < v) v = p1; if (p2 < v) v = p2; if (p3 < v) v = p3;
                n0 = v; n1 = v; n2 = v; n3 = v; end
      7:  begin v = (p0 + p1 + p2 + p3) / 4; n0 = v; n1 = v; n2 = v; n3 = v; end
      8:  begin n0 = p1; n1 = p3; n2 = p0; n3 = p2; end
      9:  begin n0 = p2; n1 = p0; n2 = p3; n3 = p1; end
      10: begin n0 = p2; n1 = p3; n2 = p0; n3 = p1; end
      11: begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
      12: begin mrow = mh / 2 - 1; mcol = mw / 2 - 1; end
      default: ;
    endcase
    mbuf[i0] = n0; mbuf[i1] = n1; mbuf[i2] = n2; mbuf[i3] = n3;
  endtask

  task automatic push_dump();
    for (int k = 0; k < 64; k++) exp_q.push_back('{a: k, d: mbuf[k]});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_m !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("busy_timeout", busy_m, 0);
  endtask

  // Reset (checking the reset outputs), then verify the 64-cycle ROM load
  task automatic start_load(input bit rand_rom);
    reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 64; k++) rom[k] = rand_rom ? 8'($urandom) : 8'(k);
    @(negedge clk);
    check("rst_busy", busy_m, 1);
    check("rst_done", done_m, 0);
    check("rst_irom_rd", rd_m, 1);
    check("rst_irom_a", ra_m, 0);
    check("rst_iram_valid", wv_m, 0);
    reset = 1'b1;
    for (int k = 0; k < 64; k++) mbuf[k] = rom[k];
    mrow = mh / 2 - 1;
    mcol = mw / 2 - 1;
    for (int k = 0; k < 64; k++) begin
      check("load_addr", ra_m, k);
      check("load_rd", rd_m, 1);
      @(negedge clk);
    end
    check("idle_busy", busy_m, 0);
    check("idle_rd", rd_m, 0);
  endtask

  // Issue one command from IDLE, optionally asserting cmd_valid while busy
  task automatic send(input int c);
    int pokes;
    wait_idle();
    if (c == 0 || c == 13) push_dump();
    else model_apply(c);
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    check("accept_busy", busy_m, 1);
    if (c == 0 || c == 13) begin
      pokes = $urandom_range(0, 10);
      for (int i = 0; i < pokes; i++) begin
        cmd = 4'($urandom);
        @(negedge clk);
      end
      cmd_valid = 1'b0;
      wait_idle();
      check("dump_drained", exp_q.size(), 0);
      check("dump_done", done_m, (c == 0) ? 1 : 0);
      if (c == 0) begin
        for (int i = 0; i < 3; i++) begin
          cmd = 4'($urandom);
          cmd_valid = 1'b1;
          @(negedge clk);
          check("done_hold", done_m, 1);
          check("done_busy", busy_m, 0);
        end
        cmd_valid = 1'b0;
      end
    end else begin
      if ($urandom_range(0, 1) == 1) cmd = 4'($urandom);
      else cmd_valid = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("exec_one_cycle", busy_m, 0);
    end
  endtask

  task automatic random_round(input int ncmds);
    int c;
    start_load(1'b1);
    for (int i = 0; i < ncmds; i++) begin
      c = $urandom_range(1, 15);
      if (c == 13 && $urandom_range(0, 3) != 0) c = 7;
      send(c);
    end
    send(0);
  endtask

  // Scoreboard monitor: every IRAM write must match the next expected pixel
  always @(negedge clk) begin
    wr_t e;
    if (wv_m === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("iram_unexpected_write", wv_m, 0);
      end else begin
        e = exp_q.pop_front();
        check("iram_addr", wa_m, e.a);
        check("iram_data", wd_m, e.d);
      end
    end else begin
      check("iram_d_when_invalid", wd_m, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    sel = 1'b0; mw = 8; mh = 8;

    start_load(1'b0); send(0);
    start_load(1'b0); send(7); send(0);
    start_load(1'b0); for (int i = 0; i < 4; i++) send(1); send(5); send(0);
    start_load(1'b0); for (int i = 0; i < 10; i++) send(4); send(9); send(0);
    start_load(1'b0); send(13); send(12); send(6); send(0);
    for (int r = 0; r < 4; r++) random_round(30);

    // Reset while the buffer is being written out
    start_load(1'b0);
    wait_idle();
    push_dump();
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    #1;
    check("abort_done", done_m, 0);
    check("abort_busy", busy_m, 1);
    check("abort_irom_a", ra_m, 0);
    check("abort_irom_rd", rd_m, 1);
    check("abort_iram_valid", wv_m, 0);
    start_load(1'b1); send(7); send(0);

    // 16x4 geometry: home (1,7), Down saturates at row 2
    sel = 1'b1; mw = 16; mh = 4;
    start_load(1'b0); for (int i = 0; i < 3; i++) send(2); send(7); send(0);
    start_load(1'b0); for (int i = 0; i < 9; i++) send(4); send(1); send(1); send(8); send(0);
    for (int r = 0; r < 2; r++) random_round(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
